// File: rtl/pe_array_sbd_distributor_pkg.sv
// Shared pe_array constants: PE count and payload width defaults, id width derivation,
// drop counter width, and the destination classification used by the distributor.
package pe_array_sbd_distributor_pkg;

  localparam int unsigned PE_NUM_DEFAULT     = 16;
  localparam int unsigned DATA_WIDTH_DEFAULT = 64;
  localparam int unsigned DROP_CNT_WIDTH     = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

  typedef enum logic [1:0] {
    DestUnicast,
    DestMulticast,
    DestInvalid
  } dest_kind_e;

  // A single PE still needs a one-bit id field.
  function automatic int unsigned pe_id_width(input int unsigned num_pe);
    return (num_pe > 1) ? $clog2(num_pe) : 1;
  endfunction

endpackage

// File: rtl/sbd_pe_fifo.sv
// Per-PE beat buffer: power-of-two ring with an occupancy counter one bit wider than
// the pointers; the head word reads as zero while the buffer is empty.
module sbd_pe_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_array_sbd_distributor.sv
// Stack-bus downstream distributor: routes each accepted beat to one PE (unicast) or an
// all-or-nothing set of PEs (multicast); undeliverable beats are dropped and counted.
module pe_array_sbd_distributor
  import pe_array_sbd_distributor_pkg::*;
#(
  parameter int unsigned NUM_PE       = PE_NUM_DEFAULT,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned PE_ID_WIDTH = pe_id_width(NUM_PE)
) (
  input  logic                           clk,
  input  logic                           reset_poweron,
  input  logic                           sbd_valid,
  output logic                           sbd_ready,
  input  logic [PE_ID_WIDTH-1:0]         sbd_pe_id,
  input  logic                           sbd_bcast,
  input  logic [NUM_PE-1:0]              sbd_bcast_mask,
  input  logic [DATA_WIDTH-1:0]          sbd_data,
  output logic [NUM_PE-1:0]              pe_valid,
  input  logic [NUM_PE-1:0]              pe_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0]   pe_data,
  input  logic                           err_clr,
  output logic                           err_bad_dest,
  output logic [DROP_CNT_WIDTH-1:0]      drop_cnt
);

  dest_kind_e          kind;
  logic [NUM_PE-1:0]   dest;
  logic [NUM_PE-1:0]   full;
  logic [NUM_PE-1:0]   empty;
  logic [NUM_PE-1:0]   push;
  logic                run_en;
  logic                accept;
  logic                drop;

  always_comb begin
    kind = DestInvalid;
    dest = '0;
    if (sbd_bcast) begin
      dest = sbd_bcast_mask;
      kind = (sbd_bcast_mask == '0) ? DestInvalid : DestMulticast;
    end else if (32'(sbd_pe_id) < NUM_PE) begin
      dest[sbd_pe_id] = 1'b1;
      kind            = DestUnicast;
    end
  end

  // Ready sees only the destination decode and registered full flags, never pe_ready.
  assign sbd_ready = run_en && !(|(dest & full));
  assign accept    = sbd_valid && sbd_ready;
  assign drop      = accept && (kind == DestInvalid);
  assign push      = {NUM_PE{accept}} & dest;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      run_en <= 1'b0;
    end else begin
      run_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      err_bad_dest <= 1'b0;
      drop_cnt     <= '0;
    end else if (err_clr) begin
      err_bad_dest <= drop;
      drop_cnt     <= drop ? DROP_CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      err_bad_dest <= 1'b1;
      if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    assign pe_valid[i] = !empty[i];

    sbd_pe_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (push[i]),
      .push_data     (sbd_data),
      .pop           (pe_valid[i] && pe_ready[i]),
      .full          (full[i]),
      .empty         (empty[i]),
      .data          (pe_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_array_sbd_distributor.sv
// Bench for the distributor: directed corner sequences, a ready-decode table and a
// randomized run against per-PE queue models; a 3-PE instance covers out-of-range ids.
`timescale 1ns/1ps
module tb_pe_array_sbd_distributor;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic              sbd_valid = 0, sbd_ready, sbd_bcast = 0, err_clr = 0, err_bad_dest;
  logic [1:0]        sbd_pe_id = 0;
  logic [NP-1:0]     sbd_bcast_mask = 0, pe_valid, pe_ready = 0;
  logic [DW-1:0]     sbd_data = 0;
  logic [NP*DW-1:0]  pe_data;
  logic [15:0]       drop_cnt;

  logic              d3_valid = 0, d3_ready, d3_bcast = 0, d3_err_clr = 0, d3_err;
  logic [1:0]        d3_id = 0;
  logic [2:0]        d3_mask = 0, d3_pe_valid, d3_pe_ready = 0;
  logic [DW-1:0]     d3_data = 0;
  logic [3*DW-1:0]   d3_pe_data;
  logic [15:0]       d3_drop;

  pe_array_sbd_distributor #(.NUM_PE(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) u_dut (
    .clk(clk), .reset_poweron(rst), .sbd_valid(sbd_valid), .sbd_ready(sbd_ready),
    .sbd_pe_id(sbd_pe_id), .sbd_bcast(sbd_bcast), .sbd_bcast_mask(sbd_bcast_mask),
    .sbd_data(sbd_data), .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
    .err_clr(err_clr), .err_bad_dest(err_bad_dest), .drop_cnt(drop_cnt)
  );

  pe_array_sbd_distributor #(.NUM_PE(3), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) u_dut3 (
    .clk(clk), .reset_poweron(rst), .sbd_valid(d3_valid), .sbd_ready(d3_ready),
    .sbd_pe_id(d3_id), .sbd_bcast(d3_bcast), .sbd_bcast_mask(d3_mask),
    .sbd_data(d3_data), .pe_valid(d3_pe_valid), .pe_ready(d3_pe_ready), .pe_data(d3_pe_data),
    .err_clr(d3_err_clr), .err_bad_dest(d3_err), .drop_cnt(d3_drop)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [63:0] pd(input int i);
    return pe_data[i*DW +: DW];
  endfunction

  typedef struct {
    logic       bcast;
    logic [1:0] id;
    logic [3:0] mask;
    logic [3:0] rdy;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[9];
  logic [63:0] mq [NP][$];
  logic [63:0] got [$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int acc_at;
    int beats, drops, cyc;
    logic pe2_seen, exp_rdy;
    logic [3:0] tgt, exp_pv;

    // With PE3 full and PEs 0..2 empty.
    tbl[0] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    tbl[1] = '{1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 2'd3, 4'b1111, 4'b1111, 1'b0};
    tbl[3] = '{1'b0, 2'd2, 4'b1000, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 2'd3, 4'b0000, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 2'd0, 4'b1011, 4'b1000, 1'b0};
    tbl[6] = '{1'b1, 2'd3, 4'b0111, 4'b0000, 1'b1};
    tbl[7] = '{1'b1, 2'd0, 4'b1000, 4'b0000, 1'b0};
    tbl[8] = '{1'b1, 2'd2, 4'b0001, 4'b0000, 1'b1};

    // Reset state
    sbd_valid = 1; sbd_pe_id = 0; d3_valid = 1;
    #5;
    chk("rst_ready", sbd_ready, 0);
    chk("rst_ready3", d3_ready, 0);
    chk("rst_pe_valid", pe_valid, 0);
    chk("rst_pe_data_or", |pe_data, 0);
    chk("rst_err", err_bad_dest, 0);
    chk("rst_drop", drop_cnt, 0);
    sbd_valid = 0; d3_valid = 0;
    tick(); rst = 0;
    tick(); settle();
    chk("ready_after_reset", sbd_ready, 1);

    // Unicast latency
    sbd_valid = 1; sbd_pe_id = 2; sbd_data = 64'hA5;
    tick(); sbd_valid = 0; settle();
    chk("uc_pe_valid", pe_valid, 4'b0100);
    chk("uc_pe_data2", pd(2), 64'hA5);
    chk("uc_pe_data0", pd(0), 0);
    pe_ready = 4'b0100;
    tick(); pe_ready = 0; settle();
    chk("uc_drained", pe_valid, 0);

    // Fill PE1 past capacity, then drain in order
    sbd_pe_id = 1;
    for (int i = 0; i < 5; i++) begin
      sbd_valid = 1; sbd_data = 64'(i + 1); settle();
      chk($sformatf("fill_ready%0d", i), sbd_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    pe_ready = 4'b0010; acc_at = -1; got.delete();
    for (int c = 0; c < 12; c++) begin
      settle();
      if (pe_valid[1]) got.push_back(pd(1));
      if (sbd_valid && sbd_ready) acc_at = c;
      tick();
      if (acc_at == c) sbd_valid = 0;
    end
    pe_ready = 0;
    chk("fifth_accept_cycle", 64'(acc_at), 1);
    chk("fill_drain_count", 64'(got.size()), 5);
    for (int k = 0; k < 5; k++)
      if (k < got.size()) chk($sformatf("fill_order%0d", k), got[k], 64'(k + 1));

    // Multicast blocked by a full PE3
    sbd_pe_id = 3;
    for (int i = 0; i < 4; i++) begin
      sbd_valid = 1; sbd_data = 64'h31 + 64'(i); tick();
    end
    sbd_valid = 0; settle();
    chk("pe3_full_valid", pe_valid, 4'b1000);
    for (int v = 0; v < 9; v++) begin
      sbd_bcast = tbl[v].bcast; sbd_pe_id = tbl[v].id;
      sbd_bcast_mask = tbl[v].mask; pe_ready = tbl[v].rdy;
      #1;
      chk($sformatf("tbl%0d_ready", v), sbd_ready, tbl[v].exp_ready);
    end
    pe_ready = 0;
    sbd_bcast = 1; sbd_bcast_mask = 4'b1011; sbd_data = 64'hBC; sbd_valid = 1;
    #1;
    chk("mc_blocked", sbd_ready, 0);
    tick(); pe_ready = 4'b1000; settle();
    chk("mc_blocked_popping", sbd_ready, 0);
    tick(); pe_ready = 0; settle();
    chk("mc_unblocked", sbd_ready, 1);
    tick(); sbd_valid = 0; sbd_bcast = 0; settle();
    chk("mc_pe_valid", pe_valid, 4'b1011);
    chk("mc_pe0_data", pd(0), 64'hBC);
    chk("mc_pe1_data", pd(1), 64'hBC);
    chk("mc_pe2_data", pd(2), 0);
    pe_ready = 4'b1111; got.delete(); pe2_seen = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (pe_valid[3]) got.push_back(pd(3));
      if (pe_valid[2]) pe2_seen = 1;
      tick();
    end
    pe_ready = 0; settle();
    chk("mc_pe2_untouched", pe2_seen, 0);
    chk("mc_pe3_count", 64'(got.size()), 4);
    if (got.size() == 4) begin
      chk("mc_pe3_b0", got[0], 64'h32);
      chk("mc_pe3_b3", got[3], 64'hBC);
    end
    chk("mc_all_drained", pe_valid, 0);

    // Invalid destinations on the 3-PE instance
    d3_valid = 1; d3_bcast = 1; d3_mask = 0; settle();
    chk("bad_mask_ready", d3_ready, 1);
    tick(); d3_bcast = 0; d3_id = 3; settle();
    chk("bad_id_ready", d3_ready, 1);
    tick(); d3_valid = 0; settle();
    chk("bad_err", d3_err, 1);
    chk("bad_drop", d3_drop, 2);
    chk("bad_no_delivery", d3_pe_valid, 0);
    d3_err_clr = 1; tick(); d3_err_clr = 0; settle();
    chk("clr_err", d3_err, 0);
    chk("clr_drop", d3_drop, 0);
    d3_valid = 1; d3_err_clr = 1; tick(); d3_valid = 0; d3_err_clr = 0; settle();
    chk("clr_coincide_err", d3_err, 1);
    chk("clr_coincide_drop", d3_drop, 1);
    d3_valid = 1; d3_id = 2; d3_data = 64'h77; tick(); d3_valid = 0; settle();
    chk("d3_uc_valid", d3_pe_valid, 3'b100);
    chk("d3_uc_drop", d3_drop, 1);

    // Reset mid-stream
    sbd_pe_id = 0; sbd_bcast = 0;
    for (int i = 0; i < 3; i++) begin
      sbd_valid = 1; sbd_data = 64'h51 + 64'(i); tick();
    end
    sbd_data = 64'h54;
    rst = 1; settle();
    chk("mid_rst_pe_valid", pe_valid, 0);
    chk("mid_rst_pe_data_or", |pe_data, 0);
    chk("mid_rst_ready", sbd_ready, 0);
    tick(); rst = 0; sbd_valid = 0; settle();
    chk("post_rst_pe_valid", pe_valid, 0);
    tick(); settle();
    chk("post_rst_ready", sbd_ready, 1);
    pe_ready = 4'b1111; tick(); tick(); settle();
    chk("no_stale", pe_valid, 0);
    pe_ready = 0;

    // Randomized traffic against per-PE queues
    beats = 0; drops = 0; cyc = 0;
    for (int i = 0; i < NP; i++) mq[i].delete();
    while (beats < 10000 && cyc < 40000) begin
      sbd_valid = ($urandom_range(0, 3) != 0);
      sbd_bcast = ($urandom_range(0, 3) == 0);
      sbd_pe_id = 2'($urandom);
      sbd_bcast_mask = 4'($urandom);
      sbd_data = {$urandom, $urandom};
      pe_ready = 4'($urandom);
      settle();
      tgt = sbd_bcast ? sbd_bcast_mask : (4'b0001 << sbd_pe_id);
      exp_rdy = 1;
      for (int i = 0; i < NP; i++) begin
        if (tgt[i] && mq[i].size() == FD) exp_rdy = 0;
        exp_pv[i] = (mq[i].size() != 0);
      end
      chk("rand_ready", sbd_ready, exp_rdy);
      chk("rand_pe_valid", pe_valid, exp_pv);
      for (int i = 0; i < NP; i++)
        if (exp_pv[i]) chk($sformatf("rand_data_pe%0d", i), pd(i), mq[i][0]);
      for (int i = 0; i < NP; i++)
        if (exp_pv[i] && pe_ready[i]) void'(mq[i].pop_front());
      if (sbd_valid && exp_rdy) begin
        beats++;
        if (tgt == 0) drops++;
        else for (int i = 0; i < NP; i++) if (tgt[i]) mq[i].push_back(sbd_data);
      end
      cyc++;
      tick();
    end
    chk("rand_budget", (beats >= 10000) ? 1'b1 : 1'b0, 1);
    sbd_valid = 0; pe_ready = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      settle();
      for (int i = 0; i < NP; i++) exp_pv[i] = (mq[i].size() != 0);
      chk("drain_pe_valid", pe_valid, exp_pv);
      for (int i = 0; i < NP; i++)
        if (exp_pv[i]) begin
          chk($sformatf("drain_data_pe%0d", i), pd(i), mq[i][0]);
          void'(mq[i].pop_front());
        end
      tick();
    end
    pe_ready = 0; settle();
    chk("rand_final_empty", pe_valid, 0);
    chk("rand_drop_cnt", drop_cnt, (drops > 65535) ? 16'hFFFF : 16'(drops));
    chk("rand_err", err_bad_dest, (drops > 0) ? 1'b1 : 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
